// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: control-word layout and opcodes, used by the datapath and the controller.
package sap1_pkg;

    localparam int CTRL_W = 12;

    localparam int HLT_BIT       = 11;
    localparam int PC_INC_BIT    = 10;
    localparam int PC_EN_BIT     = 9;
    localparam int MEM_LOAD_BIT  = 8;
    localparam int MEM_EN_BIT    = 7;
    localparam int IR_LOAD_BIT   = 6;
    localparam int IR_EN_BIT     = 5;
    localparam int A_LOAD_BIT    = 4;
    localparam int A_EN_BIT      = 3;
    localparam int B_LOAD_BIT    = 2;
    localparam int ADDER_SUB_BIT = 1;
    localparam int ADDER_EN_BIT  = 0;

    typedef logic [CTRL_W-1:0] ctrl_word_t;

    typedef enum logic [3:0] {
        OP_LDA = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_HLT = 4'hF
    } opcode_e;

    // One-hot control-word mask for a single control bit.
    function automatic ctrl_word_t ctrl_bit(input int idx);
        ctrl_bit = ctrl_word_t'(1) << idx;
    endfunction

endpackage

// File: rtl/sap1_ram.sv
// SAP-1 program/data memory: synchronous write, asynchronous read.
module sap1_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    // NOTE: memory arrays get no reset so they map onto RAM cells and keep the program across rst.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sap1_datapath.sv
// SAP-1 datapath: muxed bus, PC, MAR, IR, A/B registers, add/sub ALU with flags, sticky halt.
module sap1_datapath
    import sap1_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CTRL_W-1:0]        ctrl_word,
    input  logic                     prog_we,
    input  logic [ADDR_W-1:0]        prog_addr,
    input  logic [DATA_W-1:0]        prog_data,
    output logic [DATA_W-ADDR_W-1:0] opcode,
    output logic [DATA_W-1:0]        bus,
    output logic [DATA_W-1:0]        a_out,
    output logic [ADDR_W-1:0]        pc_out,
    output logic                     carry,
    output logic                     zero,
    output logic                     halted
);

    logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
    logic [DATA_W-1:0] ir_q, ir_d, a_q, a_d, b_q, b_d;
    logic              carry_q, carry_d, zero_q, zero_d, halted_q, halted_d;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W:0]   sum_ext;
    logic              sub;
    logic              update_en;

    sap1_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (prog_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (mar_q),
        .rdata (ram_rdata)
    );

    // Subtraction as a + ~b + 1; the extra MSB is carry-out (1 = no borrow).
    assign sub     = ctrl_word[ADDER_SUB_BIT];
    assign sum_ext = {1'b0, a_q} + {1'b0, b_q ^ {DATA_W{sub}}} + (DATA_W+1)'(sub);

    always_comb begin
        if (ctrl_word[ADDER_EN_BIT])    bus = sum_ext[DATA_W-1:0];
        else if (ctrl_word[A_EN_BIT])   bus = a_q;
        else if (ctrl_word[IR_EN_BIT])  bus = {{(DATA_W-ADDR_W){1'b0}}, ir_q[ADDR_W-1:0]};
        else if (ctrl_word[MEM_EN_BIT]) bus = ram_rdata;
        else if (ctrl_word[PC_EN_BIT])  bus = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
        else                            bus = '0;
    end

    // An HLT edge is itself frozen, as is every edge after it.
    assign update_en = !halted_q && !ctrl_word[HLT_BIT];

    // NOTE: every signal gets a hold default first so no path through this block can infer a latch.
    always_comb begin
        pc_d     = pc_q;
        mar_d    = mar_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        halted_d = halted_q | ctrl_word[HLT_BIT];
        if (update_en) begin
            if (ctrl_word[PC_INC_BIT])   pc_d  = pc_q + ADDR_W'(1);
            if (ctrl_word[MEM_LOAD_BIT]) mar_d = bus[ADDR_W-1:0];
            if (ctrl_word[IR_LOAD_BIT])  ir_d  = bus;
            if (ctrl_word[A_LOAD_BIT])   a_d   = bus;
            if (ctrl_word[B_LOAD_BIT])   b_d   = bus;
            if (ctrl_word[ADDER_EN_BIT] && ctrl_word[A_LOAD_BIT]) begin
                carry_d = sum_ext[DATA_W];
                zero_d  = (sum_ext[DATA_W-1:0] == '0);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all loads sample the same pre-edge bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= '0;
            mar_q    <= '0;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            mar_q    <= mar_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            halted_q <= halted_d;
        end
    end

    assign opcode = ir_q[DATA_W-1:ADDR_W];
    assign a_out  = a_q;
    assign pc_out = pc_q;
    assign carry  = carry_q;
    assign zero   = zero_q;
    assign halted = halted_q;

endmodule

// File: doc/sap1_datapath.md
SAP1_DATAPATH -- requirements
Module: sap1_datapath

Interface
REQ-001 Parameter: DATA_W, 8, bus/register/RAM word width.
REQ-002 Parameter: ADDR_W, 4, PC/MAR/RAM address width; opcode width = DATA_W-ADDR_W.
REQ-003 Port: clk  input  1  datapath clock; all registers update on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: ctrl_word  input  12  control word from the controller; bits 11..0 = HLT, PC_INC, PC_EN, MEM_LOAD, MEM_EN, IR_LOAD, IR_EN, A_LOAD, A_EN, B_LOAD, ADDER_SUB, ADDER_EN.
REQ-006 Port: prog_we  input  1  RAM program-write strobe.
REQ-007 Port: prog_addr  input  ADDR_W  RAM program-write address.
REQ-008 Port: prog_data  input  DATA_W  RAM program-write data.
REQ-009 Port: opcode  output  4  ir[7:4], fed to the controller.
REQ-010 Port: bus  output  DATA_W  current internal bus value (observation).
REQ-011 Port: a_out  output  DATA_W  accumulator A.
REQ-012 Port: pc_out  output  ADDR_W  program counter.
REQ-013 Port: carry, zero  output  1 each  ALU flags.
REQ-014 Port: halted  output  1  sticky halt indicator.

Function
REQ-015 The bus SHALL be a mux, not tristate; source priority ADDER_EN > A_EN > IR_EN > MEM_EN > PC_EN; no enable -> 0x00.
REQ-016 Bus sources SHALL be: ADDER -> alu result; A -> a; IR -> {0000, ir[3:0]}; MEM -> ram[mar]; PC -> {0000, pc}.
REQ-017 ALU SHALL be combinational: ADDER_SUB=0 -> a+b, =1 -> a-b (a + ~b + 1), result mod 2^DATA_W.
REQ-018 On rising clk while not halted: PC_INC -> pc+1 (15 wraps to 0); MEM_LOAD -> mar <= bus[3:0]; IR_LOAD -> ir <= bus; A_LOAD -> a <= bus; B_LOAD -> b <= bus; multiple loads in one cycle all SHALL take effect from the same bus value.
REQ-019 Flags SHALL update only on an edge with ADDER_EN and A_LOAD both set: carry = adder carry-out (for SUB, 1 = no borrow); zero = (result == 0); otherwise hold.
REQ-020 HLT set at a rising edge SHALL set halted at that edge; halted SHALL stay 1 until rst; loads and PC_INC at that edge and after SHALL be ignored.
REQ-021 prog_we SHALL write ram[prog_addr] <= prog_data on rising clk regardless of halted or ctrl_word; RAM read SHALL be asynchronous; a write and MEM_EN to the same address in one cycle SHALL return the old value on the bus that cycle.
REQ-022 opcode SHALL be combinational from ir; load takes effect one rising edge after IR_LOAD asserted.

Reset
REQ-023 rst SHALL asynchronously clear pc, mar, ir, a, b, carry, zero, halted to 0; opcode=0, bus=0x00 with ctrl_word=0.
REQ-024 RAM contents SHALL NOT be cleared by rst; prog_we SHALL be honoured during rst.
REQ-025 rst mid-instruction SHALL abandon the instruction; the first edge after release executes from pc=0.

Structure
REQ-026 Control-bit indices, opcodes (LDA=0, ADD=1, SUB=2, HLT=F) and ctrl_word width SHALL live in a shared package used by datapath and controller.
REQ-027 RAM SHALL be one sub-module, sap1_ram (2^ADDR_W x DATA_W, sync write, async read).

Verification
REQ-028 Assert rst with ctrl_word=0 -> pc_out=0, a_out=0x00, opcode=0, carry=0, zero=0, halted=0, bus=0x00.
REQ-029 16 cycles PC_INC from 0 -> pc_out=0 (wrap), PC_EN shows bus=0x00; 3 more -> 0x03.
REQ-030 a=0xF0, b=0x20, ADDER_EN|A_LOAD|A_EN|PC_EN -> bus=0x10 (priority), next a=0x10, carry=1, zero=0.
REQ-031 a=0x05, b=0x05, ADDER_SUB|ADDER_EN|A_LOAD -> a=0x00, zero=1, carry=1; a=0x03, b=0x05 -> a=0xFE, carry=0.
REQ-032 HLT one cycle, then A_LOAD with PC_EN -> halted=1, a_out unchanged, pc frozen; prog_we still writes RAM; rst clears halted.
REQ-033 With controller: program 0x09,0x1A,0x2B,0xF0, ram[9]=0x1C, ram[A]=0x0E, ram[B]=0x04 -> a_out 0x1C, 0x2A, 0x26, then halted=1, pc_out=4.
